// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multi-cycle multiply/divide unit for the EX stage.
//
// Owns the architectural HI/LO registers. A mul/div is issued when the unit is
// idle: the full 64-bit result is computed on the issue edge into a pending
// register, and a down-counter models the operation latency. The result is
// copied into {HI,LO} on the edge where the counter steps from 1 to 0. The
// new value is therefore visible MUL_CYCLES / DIV_CYCLES cycles after issue.
// mthi/mtlo write HI/LO directly in a single cycle when the unit is idle.
// Any request that arrives while an operation is in flight is ignored. Stall
// detection upstream keeps such requests from reaching this unit.
//
// Optional feature (macro MD_MADD_EN):
//   MDFunc 5 = madd, MDFunc 6 = msub: {HI,LO} <= {HI,LO} +/- product.
//   The accumulate value is sampled at issue. These ops use MUL_CYCLES and
//   follow the same busy, issue and commit rules as mul. Without the macro,
//   codes 5..7 are no-ops and do not raise md_busy.
//
// Parameters:
//   MUL_CYCLES  cycles from mul/madd/msub issue to HI/LO commit (1..15)
//   DIV_CYCLES  cycles from div issue to HI/LO commit (1..15)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   md_valid  in   EX holds a live instruction; qualifies MDFunc
//   MDFunc    in   [2:0] 0 none, 1 mthi, 2 mtlo, 3 mul, 4 div (5 madd, 6 msub)
//   MDSign    in   1 signed, 0 unsigned
//   srcA      in   [31:0] rs operand (forwarded)
//   srcB      in   [31:0] rt operand (forwarded)
//   HI        out  [31:0] HI register
//   LO        out  [31:0] LO register
//   md_busy   out  operation in flight, or being issued this cycle
// -----------------------------------------------------------------------------
module md_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  MDFunc,
    input  logic        MDSign,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_busy
);

    // -------------------------------------------------------------------------
    // Function codes and latency constants
    // -------------------------------------------------------------------------
    localparam logic [2:0] FN_NONE = 3'd0;
    localparam logic [2:0] FN_MTHI = 3'd1;
    localparam logic [2:0] FN_MTLO = 3'd2;
    localparam logic [2:0] FN_MUL  = 3'd3;
    localparam logic [2:0] FN_DIV  = 3'd4;
`ifdef MD_MADD_EN
    localparam logic [2:0] FN_MADD = 3'd5;
    localparam logic [2:0] FN_MSUB = 3'd6;
`endif

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] pending_q;   // full result waiting for commit
    logic [3:0]  count_q;     // cycles remaining until commit; 0 = idle

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic idle;
    logic is_mthi;
    logic is_mtlo;
    logic is_mul;
    logic is_div;
    logic is_madd;
    logic is_msub;
    logic md_req;       // a multi-cycle op is presented (busy term)
    logic issue;        // that op is accepted on this edge

    assign idle    = (count_q == 4'd0);
    assign is_mthi = (MDFunc == FN_MTHI);
    assign is_mtlo = (MDFunc == FN_MTLO);
    assign is_mul  = (MDFunc == FN_MUL);
    assign is_div  = (MDFunc == FN_DIV);
`ifdef MD_MADD_EN
    assign is_madd = (MDFunc == FN_MADD);
    assign is_msub = (MDFunc == FN_MSUB);
`else
    assign is_madd = 1'b0;
    assign is_msub = 1'b0;
`endif

    assign md_req  = md_valid && (is_mul || is_div || is_madd || is_msub);
    assign issue   = md_req && idle;
    assign md_busy = !idle || md_req;

    // -------------------------------------------------------------------------
    // Multiplier
    // Extending both operands to 64 bits (sign- or zero-extension per MDSign)
    // makes the low 64 bits of a plain unsigned multiply equal to the correct
    // two's-complement product in both modes.
    // -------------------------------------------------------------------------
    logic [63:0] op_a_ext;
    logic [63:0] op_b_ext;
    logic [63:0] product;

    assign op_a_ext = MDSign ? {{32{srcA[31]}}, srcA} : {32'd0, srcA};
    assign op_b_ext = MDSign ? {{32{srcB[31]}}, srcB} : {32'd0, srcB};
    assign product  = op_a_ext * op_b_ext;

    // -------------------------------------------------------------------------
    // Divider
    // Signed division is done on magnitudes, then the signs are restored:
    // the quotient is negative when the operand signs differ (truncation
    // toward zero), and the remainder follows the dividend. The overflow case
    // 80000000 / FFFFFFFF falls out naturally: |a| = 80000000, |b| = 1, the
    // signs match, so the quotient stays 80000000 and the remainder is 0.
    // -------------------------------------------------------------------------
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_b_safe;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign neg_a       = MDSign && srcA[31];
    assign neg_b       = MDSign && srcB[31];
    assign mag_a       = neg_a ? (~srcA + 32'd1) : srcA;
    assign mag_b       = neg_b ? (~srcB + 32'd1) : srcB;
    assign div_by_zero = (srcB == 32'd0);

    // Keep the divider operand nonzero so its result is always defined; the
    // zero-divisor case is replaced below anyway.
    assign mag_b_safe  = div_by_zero ? 32'd1 : mag_b;
    assign mag_q       = mag_a / mag_b_safe;
    assign mag_r       = mag_a % mag_b_safe;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        quotient  = 32'd0;
        remainder = 32'd0;
        if (div_by_zero) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = srcA;
        end else begin
            quotient  = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
            remainder = neg_a           ? (~mag_r + 32'd1) : mag_r;
        end
    end

    // -------------------------------------------------------------------------
    // Result selection and latency load value for an issuing op
    // -------------------------------------------------------------------------
    logic [63:0] issue_result;
    logic [3:0]  issue_count;

    always_comb begin
        issue_result = product;
        issue_count  = MUL_LOAD;
        if (is_div) begin
            issue_result = {remainder, quotient};
            issue_count  = DIV_LOAD;
        end
`ifdef MD_MADD_EN
        else if (is_madd) begin
            // Accumulator is the architectural {HI,LO} at the issue edge.
            issue_result = {hi_q, lo_q} + product;
        end else if (is_msub) begin
            issue_result = {hi_q, lo_q} - product;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // State update
    // Priority: an in-flight op owns the unit until it commits; while idle, a
    // multi-cycle issue, mthi or mtlo may act. Only one of those can be
    // presented per cycle since they are decoded from a single MDFunc.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the values from before the clock edge.
        if (!reset) begin
            // NOTE: the pending register is reset along with HI/LO so a
            // discarded operation can never leak a stale result later.
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pending_q <= 64'd0;
            count_q   <= 4'd0;
        end else if (!idle) begin
            count_q <= count_q - 4'd1;
            if (count_q == 4'd1) begin
                hi_q <= pending_q[63:32];
                lo_q <= pending_q[31:0];
            end
        end else if (issue) begin
            pending_q <= issue_result;
            count_q   <= issue_count;
        end else if (md_valid && is_mthi) begin
            hi_q <= srcA;
        end else if (md_valid && is_mtlo) begin
            lo_q <= srcA;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- self-checking bench for md_unit.
//
// A reference model computes HI/LO and the busy flag from arithmetic on
// 64-bit integers and an absolute commit-edge timestamp. Directed cases cover
// the documented examples (signed/unsigned mul, back-to-back issue, signed
// div, overflow, divide by zero, mthi/mtlo, ignore-while-busy, reset mid-op,
// madd when MD_MADD_EN is defined), followed by a randomized legal stream.
// -----------------------------------------------------------------------------
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_valid;
    logic [2:0]  MDFunc;
    logic        MDSign;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        md_busy;

    md_unit #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md_valid(md_valid),
        .MDFunc  (MDFunc),
        .MDSign  (MDSign),
        .srcA    (srcA),
        .srcB    (srcB),
        .HI      (HI),
        .LO      (LO),
        .md_busy (md_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    bit          m_inflight;
    int          m_edge;        // edges seen since reset release
    int          m_commit_edge; // edge on which m_pend lands in {HI,LO}
    int          busy_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_md(input logic [2:0] f);
`ifdef MD_MADD_EN
        return (f == 3'd3) || (f == 3'd4) || (f == 3'd5) || (f == 3'd6);
`else
        return (f == 3'd3) || (f == 3'd4);
`endif
    endfunction

    function automatic int latency(input logic [2:0] f);
        return (f == 3'd4) ? DIV_N : MUL_N;
    endfunction

    // {HI,LO} result of an MD op, from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] f, input logic s,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] hi, input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        if (f == 3'd4) begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'd0, a});
                sb = longint'({32'd0, b});
            end
            q = sa / sb;   // truncates toward zero; remainder follows dividend
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = longint'(sa * sb);
        end else begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            p  = ua * ub;
        end
        if (f == 3'd5) return {hi, lo} + p;
        if (f == 3'd6) return {hi, lo} - p;
        return p;
    endfunction

    task automatic model_reset();
        m_hi       = 32'd0;
        m_lo       = 32'd0;
        m_pend     = 64'd0;
        m_inflight = 1'b0;
        m_edge     = 0;
        m_commit_edge = 0;
    endtask

    // One cycle: present inputs, check busy before the edge, advance the model
    // across the edge, then check HI/LO after it. Entered at posedge+1.
    task automatic step(input logic v, input logic [2:0] f, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
        md_valid = v;
        MDFunc   = f;
        MDSign   = s;
        srcA     = a;
        srcB     = b;
        #1;
        check("busy", md_busy, m_inflight || (v && is_md(f)));
        if (md_busy) busy_seen++;
        @(posedge clk);
        m_edge++;
        if (m_inflight) begin
            if (m_edge == m_commit_edge) begin
                {m_hi, m_lo} = m_pend;
                m_inflight   = 1'b0;
            end
        end else if (v) begin
            if (is_md(f)) begin
                m_pend        = ref_result(f, s, a, b, m_hi, m_lo);
                m_commit_edge = m_edge + latency(f);
                m_inflight    = 1'b1;
            end else if (f == 3'd1) begin
                m_hi = a;
            end else if (f == 3'd2) begin
                m_lo = a;
            end
        end
        #1;
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset    = 1'b0;
        md_valid = 1'b0;
        MDFunc   = 3'd0;
        MDSign   = 1'b0;
        srcA     = 32'd0;
        srcB     = 32'd0;
        model_reset();
        #1;
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", md_busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Signed mul: -3 * 7, busy for exactly MUL_N cycles after issue
        step(1'b1, 3'd3, 1'b1, 32'hFFFF_FFFD, 32'd7);
        busy_seen = 0;
        idle_steps(MUL_N);
        check("smul_busy_cycles", busy_seen, MUL_N);
        check("smul", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Unsigned mul, then divu on the first idle cycle
        step(1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd2);
        idle_steps(MUL_N);
        check("umul", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        check("umul_idle", md_busy, 1'b0);
        step(1'b1, 3'd4, 1'b0, 32'hFFFF_FFFE, 32'd3);
        idle_steps(DIV_N);
        check("divu_b2b", {HI, LO}, 64'h0000_0002_5555_5554);

        // Signed div -7 / 2, then overflow case
        step(1'b1, 3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
        idle_steps(DIV_N);
        check("sdiv", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        step(1'b1, 3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        idle_steps(DIV_N);
        check("sdiv_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

        // Divide by zero, unsigned and signed
        step(1'b1, 3'd4, 1'b0, 32'd7, 32'd0);
        idle_steps(DIV_N);
        check("divu_zero", {HI, LO}, 64'h0000_0007_FFFF_FFFF);
        step(1'b1, 3'd4, 1'b1, 32'h8000_0001, 32'd0);
        idle_steps(DIV_N);
        check("sdiv_zero", {HI, LO}, 64'h8000_0001_FFFF_FFFF);

        // mthi: single cycle, no busy
        step(1'b1, 3'd1, 1'b0, 32'h1234_5678, 32'd0);
        check("mthi", HI, 32'h1234_5678);
        check("mthi_busy", md_busy, 1'b0);

        // mtlo while a div is in flight is ignored
        step(1'b1, 3'd4, 1'b0, 32'd100, 32'd7);
        step(1'b1, 3'd2, 1'b0, 32'hDEAD_BEEF, 32'd0);
        check("mtlo_ignored", LO, 32'hFFFF_FFFF);
        idle_steps(DIV_N - 1);
        check("div_after_mtlo", {HI, LO}, 64'h0000_0002_0000_000E);

        // Reset mid-op: no later commit
        step(1'b1, 3'd3, 1'b0, 32'd3, 32'd4);
        idle_steps(2);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check("rstmid_hi", HI, 32'd0);
        check("rstmid_lo", LO, 32'd0);
        check("rstmid_busy", md_busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle_steps(MUL_N + 3);
        check("rstmid_nocommit", {HI, LO}, 64'd0);

`ifdef MD_MADD_EN
        // madd 2*3 onto {0, FFFFFFFF}
        step(1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd0);
        step(1'b1, 3'd5, 1'b1, 32'd2, 32'd3);
        idle_steps(MUL_N);
        check("madd", {HI, LO}, 64'h0000_0001_0000_0005);
`endif

        // Randomized legal stream: no MD/mthi/mtlo request while busy
        for (int i = 0; i < 1500; i++) begin
            logic       v;
            logic [2:0] f;
            v = ($urandom_range(0, 7) != 0);
            f = 3'($urandom_range(0, 7));
            if (m_inflight && v) f = 3'd0;
            step(v, f, 1'($urandom_range(0, 1)), rand_operand(), rand_operand());
        end
        idle_steps(DIV_N + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
